counter_run_ctrl: RTL and testbench
===================================

COUNTER_RUN_CTRL -- requirements
Module: counter_run_ctrl

Interface
REQ-001 Parameter N, default 10, counter modulus (count range 0..N-1), N >= 2.
REQ-002 Parameter CNT_WIDTH, default 4, width of count_out, 2**CNT_WIDTH >= N.
REQ-003 Parameter WRAP_WIDTH, default 8, width of num_wraps and wraps_left.
REQ-004 clk  input  1  sole clock; all state updates on rising edge.
REQ-005 reset_n  input  1  asynchronous, active-low reset.
REQ-006 start  input  1  request a run; sampled only in IDLE.
REQ-007 num_wraps  input  WRAP_WIDTH  number of full 0..N-1 passes per run; latched with start.
REQ-008 pause  input  1  level; freezes the count while high during a run.
REQ-009 abort  input  1  terminates a run without done.
REQ-010 busy  output  1  high in RUN and PAUSE.
REQ-011 done  output  1  one-cycle pulse on normal run completion.
REQ-012 aborted  output  1  one-cycle pulse on abort.
REQ-013 wrap_pulse  output  1  one-cycle pulse each time the count wraps N-1 -> 0.
REQ-014 count_out  output  CNT_WIDTH  current count, registered.
REQ-015 wraps_left  output  WRAP_WIDTH  passes remaining in the current run, registered.

Function
REQ-016 The block SHALL implement FSM states IDLE, RUN, PAUSE, DONE; all outputs registered.
REQ-017 IDLE: count_out=0, busy=0; start=1 with num_wraps!=0 -> RUN at that edge, wraps_left=num_wraps, busy=1, count_out=0.
REQ-018 IDLE: start=1 with num_wraps=0 -> DONE, no counting, wraps_left=0.
REQ-019 RUN, pause=0, abort=0: count_out increments by 1 per edge.
REQ-020 RUN at count_out=N-1: count_out->0, wrap_pulse=1 for that cycle, wraps_left decrements.
REQ-021 RUN at count_out=N-1 with wraps_left=1: state->DONE, count_out=0, wraps_left=0, wrap_pulse=1, busy=0.
REQ-022 Completion latency: done asserts exactly num_wraps*N+1 cycles after the start edge, assuming no pause.
REQ-023 DONE: done=1 for exactly one cycle, then IDLE unconditionally; start sampled during DONE SHALL be ignored.
REQ-024 RUN with pause=1 -> PAUSE; count_out and wraps_left do not change at that edge.
REQ-025 PAUSE holds count_out and wraps_left; pause=0 -> RUN with no increment at that edge.
REQ-026 abort=1 in RUN or PAUSE has priority over pause and terminal count: -> IDLE, count_out=0, wraps_left=0, aborted=1 one cycle, no done, no wrap_pulse.
REQ-027 abort in IDLE or DONE SHALL be ignored; start while busy SHALL be ignored.
REQ-028 count_out SHALL never exceed N-1; wraps_left SHALL never underflow.

Reset
REQ-029 reset_n=0 SHALL immediately force IDLE, count_out=0, wraps_left=0, busy=0, done=0, aborted=0, wrap_pulse=0, independent of clk.
REQ-030 Reset asserted mid-run SHALL discard the run with no done or aborted pulse; first start after release SHALL behave as from cold reset.

Structure
REQ-031 A shared package SHALL hold the FSM state encoding (IDLE, RUN, PAUSE, DONE) and the default values of N, CNT_WIDTH, WRAP_WIDTH.
REQ-032 The modulo count SHALL be one sub-module, mod_counter_clr: modulo-N counter with enable, synchronous clear and terminal-count output, same clk/reset_n.
REQ-033 counter_run_ctrl SHALL contain only the FSM, wraps_left register and output pulse registers around mod_counter_clr.

Verification (N=10, CNT_WIDTH=4)
REQ-034 Reset then start with num_wraps=2 -> count 0..9,0..9; wrap_pulse twice; done high 21 cycles after start edge; busy low with done.
REQ-035 start with num_wraps=0 -> done one cycle after start edge, busy never high, count_out stays 0.
REQ-036 num_wraps=1, pause high 3 cycles at count_out=4 -> count_out holds 4 for 3 cycles, done delayed by 3 cycles (14 cycles after start).
REQ-037 num_wraps=3, abort at count_out=7 of pass 2 -> aborted one cycle, count_out=0, wraps_left=0, no done; start during the run ignored.
REQ-038 num_wraps=2, reset_n low mid-run at count_out=5 -> outputs zero immediately without clk edge; new start with num_wraps=1 -> done 11 cycles later.
REQ-039 abort and pause together at count_out=9, wraps_left=1 -> aborted, no done, no wrap_pulse.

Source files
------------

// File: rtl/counter_run_ctrl_pkg.sv
// counter_run_ctrl_pkg
// Shared definitions for the run controller and its modulo counter:
//   - FSM state encoding (IDLE, RUN, PAUSE, DONE)
//   - default values for the modulus and the two data widths
package counter_run_ctrl_pkg;

  localparam int N_DEF          = 10;  // counter modulus, count range 0..N-1
  localparam int CNT_WIDTH_DEF  = 4;   // width of count_out, 2**CNT_WIDTH >= N
  localparam int WRAP_WIDTH_DEF = 8;   // width of num_wraps / wraps_left

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

endpackage : counter_run_ctrl_pkg

// File: rtl/counter_run_ctrl_mod_counter_clr.sv
// mod_counter_clr
// Modulo-N up counter with enable, synchronous clear and a terminal-count flag.
// Ports:
//   clk      in   clock, rising edge
//   reset_n  in   asynchronous active-low reset, clears the count
//   en       in   advance the count by one (wraps N-1 -> 0)
//   clr      in   synchronous clear to 0, priority over en
//   count    out  current count, registered, CNT_WIDTH bits
//   tc       out  high while count == N-1
module mod_counter_clr
  import counter_run_ctrl_pkg::*;
#(
  parameter int N         = N_DEF,
  parameter int CNT_WIDTH = CNT_WIDTH_DEF
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 en,
  input  logic                 clr,
  output logic [CNT_WIDTH-1:0] count,
  output logic                 tc
);

  localparam logic [CNT_WIDTH-1:0] LAST = CNT_WIDTH'(N - 1);

  logic [CNT_WIDTH-1:0] count_q, count_d;

  // NOTE: every signal written in always_comb gets a default first, so no
  // path through the block leaves it unassigned and no latch is inferred.
  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (en) begin
      count_d = (count_q == LAST) ? '0 : count_q + CNT_WIDTH'(1);
    end
  end

  // NOTE: flops are written with non-blocking (<=) so every register samples
  // its _d value from before the edge, regardless of process ordering.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;
  assign tc    = (count_q == LAST);

endmodule : mod_counter_clr

// File: rtl/counter_run_ctrl.sv
// counter_run_ctrl
// Runs a modulo-N counter for num_wraps complete passes, with pause and abort.
// Ports:
//   clk         in   clock, rising edge
//   reset_n     in   asynchronous active-low reset
//   start       in   request a run (only looked at in IDLE)
//   num_wraps   in   passes per run, latched with start (0 -> straight to DONE)
//   pause       in   level, freezes the count while high during a run
//   abort       in   ends a run at once, no done
//   busy        out  high in RUN and PAUSE
//   done        out  one-cycle pulse on normal completion
//   aborted     out  one-cycle pulse on abort
//   wrap_pulse  out  one-cycle pulse on every N-1 -> 0 wrap
//   count_out   out  current count
//   wraps_left  out  passes remaining in the current run
module counter_run_ctrl
  import counter_run_ctrl_pkg::*;
#(
  parameter int N          = N_DEF,
  parameter int CNT_WIDTH  = CNT_WIDTH_DEF,
  parameter int WRAP_WIDTH = WRAP_WIDTH_DEF
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  start,
  input  logic [WRAP_WIDTH-1:0] num_wraps,
  input  logic                  pause,
  input  logic                  abort,
  output logic                  busy,
  output logic                  done,
  output logic                  aborted,
  output logic                  wrap_pulse,
  output logic [CNT_WIDTH-1:0]  count_out,
  output logic [WRAP_WIDTH-1:0] wraps_left
);

  state_e                state_q, state_d;
  logic [WRAP_WIDTH-1:0] wraps_left_q, wraps_left_d;
  logic                  done_q, done_d;
  logic                  aborted_q, aborted_d;
  logic                  wrap_pulse_q, wrap_pulse_d;
  logic                  cnt_en, cnt_clr, cnt_tc;

  mod_counter_clr #(
    .N         (N),
    .CNT_WIDTH (CNT_WIDTH)
  ) u_mod_counter (
    .clk     (clk),
    .reset_n (reset_n),
    .en      (cnt_en),
    .clr     (cnt_clr),
    .count   (count_out),
    .tc      (cnt_tc)
  );

  always_comb begin
    state_d      = state_q;
    wraps_left_d = wraps_left_q;
    done_d       = 1'b0;
    aborted_d    = 1'b0;
    wrap_pulse_d = 1'b0;
    cnt_en       = 1'b0;
    cnt_clr      = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        // Keeps the count pinned at 0 between runs.
        cnt_clr = 1'b1;
        if (start) begin
          wraps_left_d = num_wraps;
          state_d      = (num_wraps != '0) ? ST_RUN : ST_DONE;
        end
      end

      ST_RUN, ST_PAUSE: begin
        // Abort outranks pause and the terminal count.
        if (abort) begin
          state_d      = ST_IDLE;
          wraps_left_d = '0;
          aborted_d    = 1'b1;
          cnt_clr      = 1'b1;
        end else if (state_q == ST_PAUSE) begin
          // Resuming spends its edge without counting.
          if (!pause) state_d = ST_RUN;
        end else if (pause) begin
          state_d = ST_PAUSE;
        end else begin
          cnt_en = 1'b1;
          if (cnt_tc) begin
            wrap_pulse_d = 1'b1;
            // <= 1 rather than == 1 so wraps_left can never underflow.
            if (wraps_left_q <= WRAP_WIDTH'(1)) begin
              wraps_left_d = '0;
              state_d      = ST_DONE;
            end else begin
              wraps_left_d = wraps_left_q - WRAP_WIDTH'(1);
            end
          end
        end
      end

      ST_DONE: begin
        // done is registered from the DONE state, so it appears the cycle
        // after completion, together with the return to IDLE.
        done_d  = 1'b1;
        state_d = ST_IDLE;
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= ST_IDLE;
      wraps_left_q <= '0;
      done_q       <= 1'b0;
      aborted_q    <= 1'b0;
      wrap_pulse_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      wraps_left_q <= wraps_left_d;
      done_q       <= done_d;
      aborted_q    <= aborted_d;
      wrap_pulse_q <= wrap_pulse_d;
    end
  end

  assign busy       = (state_q == ST_RUN) || (state_q == ST_PAUSE);
  assign done       = done_q;
  assign aborted    = aborted_q;
  assign wrap_pulse = wrap_pulse_q;
  assign wraps_left = wraps_left_q;

endmodule : counter_run_ctrl

// File: tb/tb_counter_run_ctrl.sv
// tb_counter_run_ctrl
// Directed stimulus for counter_run_ctrl (N=10, CNT_WIDTH=4, WRAP_WIDTH=8).
// Each scenario pushes its hand-derived per-cycle expectations into a
// scoreboard queue; a monitor compares them on the falling clock edge and
// flags any done/aborted/wrap pulse that no scenario expected.
module tb_counter_run_ctrl;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       start = 1'b0;
  logic [7:0] num_wraps = '0;
  logic       pause = 1'b0;
  logic       abort = 1'b0;
  logic       busy, done, aborted, wrap_pulse;
  logic [3:0] count_out;
  logic [7:0] wraps_left;

  counter_run_ctrl #(
    .N          (10),
    .CNT_WIDTH  (4),
    .WRAP_WIDTH (8)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .start      (start),
    .num_wraps  (num_wraps),
    .pause      (pause),
    .abort      (abort),
    .busy       (busy),
    .done       (done),
    .aborted    (aborted),
    .wrap_pulse (wrap_pulse),
    .count_out  (count_out),
    .wraps_left (wraps_left)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         cyc;
    string      tag;
    logic [3:0] cnt;
    logic [7:0] wl;
    logic       busy;
    logic       done;
    logic       abrt;
    logic       wrap;
  } exp_t;

  exp_t sb[$];
  int   cyc    = 0;
  int   checks = 0;
  int   errors = 0;

  // cyc counts rising edges; outputs seen at the falling edge after edge k
  // belong to cycle k.
  initial forever begin
    @(posedge clk);
    cyc++;
  end

  task automatic expect_at(input int c, input string tag, input int cnt, input int wl,
                           input bit b, input bit d, input bit a, input bit w);
    exp_t e;
    e.cyc = c; e.tag = tag; e.cnt = 4'(cnt); e.wl = 8'(wl);
    e.busy = b; e.done = d; e.abrt = a; e.wrap = w;
    sb.push_back(e);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic steps(input int n);
    repeat (n) step();
  endtask

  task automatic start_run(input int nw);
    start     = 1'b1;
    num_wraps = 8'(nw);
    step();
    start = 1'b0;
  endtask

  // Monitor: scoreboard compare on the falling edge.
  initial forever begin
    exp_t e;
    logic [15:0] got, want;
    @(negedge clk);
    got = {count_out, wraps_left, busy, done, aborted, wrap_pulse};
    while (sb.size() > 0 && sb[0].cyc < cyc) begin
      e = sb.pop_front();
      checks++; errors++;
      $display("FAIL %s missed: expectation for cycle %0d never compared (now %0d)",
               e.tag, e.cyc, cyc);
    end
    if (sb.size() > 0 && sb[0].cyc == cyc) begin
      e = sb.pop_front();
      want = {e.cnt, e.wl, e.busy, e.done, e.abrt, e.wrap};
      checks++;
      if (got !== want) begin
        errors++;
        $display("FAIL %s cycle %0d: got cnt=%0d wl=%0d busy=%b done=%b abrt=%b wrap=%b, want cnt=%0d wl=%0d busy=%b done=%b abrt=%b wrap=%b",
                 e.tag, cyc, count_out, wraps_left, busy, done, aborted, wrap_pulse,
                 e.cnt, e.wl, e.busy, e.done, e.abrt, e.wrap);
      end
    end else if (done || aborted || wrap_pulse) begin
      checks++; errors++;
      $display("FAIL unexpected_pulse cycle %0d: got done=%b abrt=%b wrap=%b, want none",
               cyc, done, aborted, wrap_pulse);
    end
  end

  // Reset must clear every output at once, without waiting for a clock edge.
  initial forever begin
    @(negedge reset_n);
    #1;
    checks++;
    if ({count_out, wraps_left, busy, done, aborted, wrap_pulse} !== 16'h0) begin
      errors++;
      $display("FAIL async_reset t=%0t: got cnt=%0d wl=%0d busy=%b done=%b abrt=%b wrap=%b, want all zero",
               $time, count_out, wraps_left, busy, done, aborted, wrap_pulse);
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int s;
    steps(2);
    reset_n = 1'b1;
    expect_at(cyc + 1, "reset_state", 0, 0, 0, 0, 0, 0);
    steps(2);

    // Two passes: 0..9,0..9, wraps at +10 and +20, done at +21.
    s = cyc + 1;
    for (int k = 0; k < 20; k++)
      expect_at(s + k, "run2", k % 10, (k < 10) ? 2 : 1, 1, 0, 0, k == 10);
    expect_at(s + 20, "run2_last_wrap", 0, 0, 0, 0, 0, 1);
    expect_at(s + 21, "run2_done", 0, 0, 0, 1, 0, 0);
    start_run(2);
    steps(22);

    // Zero passes: done one cycle after start; start held into DONE is ignored.
    s = cyc + 1;
    expect_at(s,     "zero_wraps", 0, 0, 0, 0, 0, 0);
    expect_at(s + 1, "zero_done",  0, 0, 0, 1, 0, 0);
    expect_at(s + 2, "start_in_done_ignored", 0, 0, 0, 0, 0, 0);
    start     = 1'b1;
    num_wraps = 8'd0;
    step();
    num_wraps = 8'd3;
    step();
    start = 1'b0;
    steps(3);

    // One pass, pause sampled high on two edges at count 4; with the resume
    // edge the count sits at 4 for three extra cycles, done lands at +14.
    s = cyc + 1;
    for (int k = 0; k <= 12; k++)
      expect_at(s + k, "pause", (k <= 4) ? k : ((k <= 7) ? 4 : k - 3), 1, 1, 0, 0, 0);
    expect_at(s + 13, "pause_wrap", 0, 0, 0, 0, 0, 1);
    expect_at(s + 14, "pause_done", 0, 0, 0, 1, 0, 0);
    start_run(1);
    steps(4);
    pause = 1'b1;
    steps(2);
    pause = 1'b0;
    steps(10);

    // Three passes, stray start mid-run, abort at count 7 of pass 2,
    // then abort held into IDLE is ignored.
    s = cyc + 1;
    for (int k = 0; k <= 17; k++)
      expect_at(s + k, "abort_run", k % 10, (k < 10) ? 3 : 2, 1, 0, 0, k == 10);
    expect_at(s + 18, "abort_pulse", 0, 0, 0, 0, 1, 0);
    expect_at(s + 19, "abort_one_cycle", 0, 0, 0, 0, 0, 0);
    expect_at(s + 20, "abort_in_idle_ignored", 0, 0, 0, 0, 0, 0);
    start_run(3);
    steps(2);
    start     = 1'b1;
    num_wraps = 8'd5;
    step();
    start = 1'b0;
    steps(14);
    abort = 1'b1;
    steps(3);
    abort = 1'b0;
    steps(2);

    // Reset mid-run at count 5, then a fresh one-pass run: done 11 later.
    s = cyc + 1;
    for (int k = 0; k <= 4; k++)
      expect_at(s + k, "pre_reset", k, 2, 1, 0, 0, 0);
    start_run(2);
    steps(5);
    reset_n = 1'b0;
    steps(2);
    reset_n = 1'b1;
    s = cyc + 1;
    for (int k = 0; k <= 9; k++)
      expect_at(s + k, "post_reset", k, 1, 1, 0, 0, 0);
    expect_at(s + 10, "post_reset_wrap", 0, 0, 0, 0, 0, 1);
    expect_at(s + 11, "post_reset_done", 0, 0, 0, 1, 0, 0);
    start_run(1);
    steps(13);

    // Abort and pause together on the terminal count of the last pass.
    s = cyc + 1;
    for (int k = 0; k <= 9; k++)
      expect_at(s + k, "tc_abort_run", k, 1, 1, 0, 0, 0);
    expect_at(s + 10, "tc_abort_pulse", 0, 0, 0, 0, 1, 0);
    expect_at(s + 11, "tc_abort_no_done", 0, 0, 0, 0, 0, 0);
    start_run(1);
    steps(9);
    abort = 1'b1;
    pause = 1'b1;
    step();
    abort = 1'b0;
    pause = 1'b0;
    steps(2);

    // Abort while in PAUSE.
    s = cyc + 1;
    for (int k = 0; k <= 2; k++)
      expect_at(s + k, "pause_abort_run", k, 2, 1, 0, 0, 0);
    expect_at(s + 3, "pause_abort_held", 2, 2, 1, 0, 0, 0);
    expect_at(s + 4, "pause_abort_pulse", 0, 0, 0, 0, 1, 0);
    expect_at(s + 5, "pause_abort_idle", 0, 0, 0, 0, 0, 0);
    start_run(2);
    steps(2);
    pause = 1'b1;
    step();
    abort = 1'b1;
    step();
    abort = 1'b0;
    pause = 1'b0;
    steps(3);

    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending expectations, want 0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_counter_run_ctrl
